// File: rtl/forward_hazard_scoreboard.sv
// Tracks in-flight register writers behind Execute, selects the forwarding
// stage for each Execute source, and raises a load-use stall when needed.
`timescale 1ns/1ps
module forward_hazard_scoreboard #(
  parameter  int WIDTH      = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_DEPTH  = 2,
  parameter  int LOAD_STAGE = 2,
  localparam int SELW       = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*WIDTH-1:0]  RegSE,
  input  logic [NUM_SRC-1:0]        SrcUseE,
  input  logic                      ValidE,
  input  logic                      RegWE,
  input  logic                      IsLoadE,
  input  logic [WIDTH-1:0]          WriteRegE,
  input  logic                      Flush,
  input  logic                      Freeze,
  output logic [NUM_SRC*SELW-1:0]   src,
  output logic                      StallE,
  output logic                      BubbleM,
  output logic [15:0]               StallCount
);

  if (LOAD_STAGE < 1 || LOAD_STAGE > FWD_DEPTH) begin : g_bad_load_stage
    $error("forward_hazard_scoreboard: LOAD_STAGE must lie in 1..FWD_DEPTH");
  end

  logic [FWD_DEPTH:1] r_vld;
  logic [FWD_DEPTH:1] r_regw;
  logic [FWD_DEPTH:1] r_isld;
  logic [WIDTH-1:0]   r_dest [1:FWD_DEPTH];
  logic [15:0]        r_cnt;

  logic [NUM_SRC-1:0] w_haz;
  logic [SELW-1:0]    w_sel [NUM_SRC];
  logic               w_stall;
  logic               w_bubble;

  // Scan oldest to youngest so the youngest matching writer overrides.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_haz[i] = 1'b0;
      w_sel[i] = '0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (SrcUseE[i] && (RegSE[i*WIDTH +: WIDTH] != '0) && r_vld[k] &&
            r_regw[k] && (r_dest[k] == RegSE[i*WIDTH +: WIDTH])) begin
          w_sel[i] = SELW'(k);
          w_haz[i] = r_isld[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  // Reset forces every output quiet without waiting for a clock edge.
  assign w_stall  = rst && ValidE && (|w_haz);
  assign w_bubble = rst && (Flush || w_stall) && !Freeze;

  always_comb begin
    src = '0;
    if (rst && !w_stall) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src[i*SELW +: SELW] = w_sel[i];
      end
    end
  end

  assign StallE     = w_stall;
  assign BubbleM    = w_bubble;
  assign StallCount = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_cnt <= 16'd0;
    end else if (!Freeze) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
      end
      r_vld[1] <= ValidE && !(Flush || w_stall);
      if (w_stall && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Payload fields are only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!Freeze) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        r_regw[k] <= r_regw[k-1];
        r_isld[k] <= r_isld[k-1];
        r_dest[k] <= r_dest[k-1];
      end
      r_regw[1] <= RegWE;
      r_isld[1] <= IsLoadE;
      r_dest[1] <= WriteRegE;
    end
  end

endmodule

// File: doc/forward_hazard_scoreboard.md
FORWARD_HAZARD_SCOREBOARD -- requirements
Module: forward_hazard_scoreboard

Interface
REQ-001 Parameter WIDTH, 5: register-address width.
REQ-002 Parameter NUM_SRC, 2: number of source operands checked in Execute.
REQ-003 Parameter FWD_DEPTH, 2: number of tracked stages after Execute. Stage 1 = Memory, stage FWD_DEPTH = Writeback.
REQ-004 Parameter LOAD_STAGE, 2: first tracked stage whose load data is forwardable. Legal range 1..FWD_DEPTH; elaboration SHALL fail outside it.
REQ-005 Derived SELW = clog2(FWD_DEPTH+1): width of one forward select.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 RegSE  in  NUM_SRC*WIDTH  source register addresses in Execute; source i at bits [i*WIDTH +: WIDTH].
REQ-009 SrcUseE  in  NUM_SRC  source i is actually read.
REQ-010 ValidE, RegWE, IsLoadE  in  1 each  Execute instruction is valid / writes a register / is a load.
REQ-011 WriteRegE  in  WIDTH  Execute destination register.
REQ-012 Flush  in  1  kill the Execute instruction.
REQ-013 Freeze  in  1  external pipeline freeze (memory busy).
REQ-014 src  out  NUM_SRC*SELW  forward select per source. 0 = register file; k = tracked stage k.
REQ-015 StallE  out  1  load-use hazard: hold Execute.
REQ-016 BubbleM  out  1  a bubble enters stage 1 on the next edge.
REQ-017 StallCount  out  16  count of stall cycles.

Function
REQ-018 State: FWD_DEPTH entries, each holding {valid, regw, isload, dest}.
REQ-019 Entry update priority: rst, then Freeze, then Flush/StallE, then normal shift.
  - Freeze=1: all entries hold.
  - Otherwise entry k receives entry k-1, for k = 2..FWD_DEPTH, and the oldest entry is discarded.
REQ-020 Stage-1 load value:
  - Bubble (valid=0) when Flush=1 or StallE=1.
  - Otherwise {ValidE, RegWE, IsLoadE, WriteRegE}.
REQ-021 Source i match: SrcUseE[i]=1, RegSE_i != 0, and some entry k is valid with regw=1 and dest=RegSE_i. The smallest such k (youngest writer) wins.
REQ-022 Source i hazard: a match exists, the winning entry has isload=1, and k < LOAD_STAGE.
REQ-023 StallE = ValidE AND (OR of all source hazards). It is combinational from the current inputs and state.
REQ-024 src_i output:
  - k when matched and StallE=0.
  - 0 when there is no match.
  - 0 for all sources whenever StallE=1.
REQ-025 Register 0 is never forwarded and never causes a stall.
REQ-026 BubbleM = (Flush OR StallE) AND NOT Freeze.
REQ-027 StallCount increments by 1 on each edge where StallE=1 and Freeze=0. It saturates at 0xFFFF (no wrap).
REQ-028 Flush and StallE together: one bubble only; the counter still increments.
REQ-029 Outputs are still computed during Freeze, from the held state. StallCount does not change during Freeze.
REQ-030 An Execute instruction with ValidE=0 never raises StallE. It is still checked for src, with no side effects.

Reset
REQ-031 While rst=0:
  - all entries are cleared to valid=0;
  - StallCount=0, src=0, StallE=0, BubbleM=0, regardless of clk;
  - Freeze and Flush are ignored.
REQ-032 Reset asserted mid-stall clears the pending hazard immediately. The first edge after release loads stage 1 normally.

Verification (WIDTH=5, NUM_SRC=2, FWD_DEPTH=2, LOAD_STAGE=2)
REQ-033 ALU write x5 in cycle 0; consumer reading x5 on src0 in cycle 1, then another in cycle 2 -> src0=1 in cycle 1, src0=2 in cycle 2, StallE=0 throughout.
REQ-034 Load x7 in cycle 0; consumer reads x7 on src1 in cycle 1 -> cycle 1: StallE=1, BubbleM=1, src=0; cycle 2: StallE=0, src1=2, StallCount=1.
REQ-035 Writes to x3 in cycles 0 and 1; reader of x3 on src0 and src1 in cycle 2 -> src0=src1=1 (youngest wins). Writer to x0, then reader of x0 -> src=0, StallE=0.
REQ-036 Load-use stall with Freeze=1 held for 3 cycles -> entries, StallE=1 and StallCount all unchanged. After Freeze drops, exactly one stall is counted and src1=2 on the next cycle.
REQ-037 Drive 70000 consecutive stall cycles -> StallCount reaches 0xFFFF and stays there. rst=0 asynchronously mid-cycle -> StallCount=0, StallE=0, src=0 before the next edge.
